// File: rtl/bsg_dmc_ui_responder.sv
// rtl/bsg_dmc_ui_responder.sv - DMC user-interface responder backed by a small burst memory
//
// Emulates the controller side of the DMC app_* interface so UI initiators
// can be brought up in loopback without DDR, PHY or calibration.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   app_addr_i/cmd_i/en_i     command channel; app_rdy_o is its ready
//   app_wdf_*_i               write-data channel; app_wdf_rdy_o is its ready
//   app_rd_data_*_o           read-data channel (no backpressure)
//   init_calib_complete_o     high once the init counter has expired
//   cmd_err_o                 sticky protocol-error flag
//
// Optional feature macro: BSG_DMC_UI_RESPONDER_STALL_EN adds LFSR-driven
// pseudo-random backpressure on app_rdy_o / app_wdf_rdy_o.

package bsg_dmc_ui_responder_pkg;
  typedef enum logic [2:0] {
    APP_CMD_WR = 3'b000,
    APP_CMD_RD = 3'b001
  } app_cmd_e;
endpackage

module bsg_dmc_ui_responder
  import bsg_dmc_ui_responder_pkg::*;
#(
  parameter int ui_addr_width_p = 28,
  parameter int ui_data_width_p = 128,
  parameter int ui_burst_len_p  = 2,
  parameter int mem_els_p       = 16,
  parameter int addr_shift_p    = 3,
  parameter int rd_latency_p    = 4,
  parameter int init_cycles_p   = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [ui_addr_width_p-1:0]   app_addr_i,
  input  app_cmd_e                     app_cmd_i,
  input  logic                         app_en_i,
  output logic                         app_rdy_o,
  input  logic                         app_wdf_wren_i,
  input  logic [ui_data_width_p-1:0]   app_wdf_data_i,
  input  logic [ui_data_width_p/8-1:0] app_wdf_mask_i,
  input  logic                         app_wdf_end_i,
  output logic                         app_wdf_rdy_o,
  output logic                         app_rd_data_valid_o,
  output logic [ui_data_width_p-1:0]   app_rd_data_o,
  output logic                         app_rd_data_end_o,
  output logic                         init_calib_complete_o,
  output logic                         cmd_err_o
);

  localparam int DW     = ui_data_width_p;
  localparam int MW     = ui_data_width_p / 8;
  localparam int BL     = ui_burst_len_p;
  localparam int IDX_W  = $clog2(mem_els_p);
  localparam int CNT_W  = $clog2(BL + 1);
  localparam int BEAT_W = (BL > 1) ? $clog2(BL) : 1;
  localparam int LAT_W  = $clog2(rd_latency_p + 1);
  localparam int INIT_W = $clog2(init_cycles_p + 1);

  localparam logic [CNT_W-1:0]  BL_FULL   = CNT_W'(BL);
  localparam logic [CNT_W-1:0]  BL_LAST_C = CNT_W'(BL - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BL - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(rd_latency_p);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(init_cycles_p - 1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_WAIT, S_RD_DATA} state_e;

  state_e              state_q, state_d;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic                calib_q, calib_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic [DW-1:0]       wbuf_q [BL];
  logic [DW-1:0]       wbuf_d [BL];
  logic [MW-1:0]       wmask_q [BL];
  logic [MW-1:0]       wmask_d [BL];
  logic [DW-1:0]       mem_q [mem_els_p][BL];
  logic [DW-1:0]       mem_d [mem_els_p][BL];
  logic [IDX_W-1:0]    addr_idx_q, addr_idx_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_end_q, rd_end_d;
  logic [DW-1:0]       rd_data_q, rd_data_d;
  logic                err_q, err_d;

  logic                cmd_gate, wdf_gate;
  logic                cmd_acc, wdf_acc;
  logic [IDX_W-1:0]    cmd_idx;
  logic                addr_unused;

  // Bits outside the index field are intentionally ignored (aliasing).
  assign addr_unused = ^app_addr_i;
  assign cmd_idx     = app_addr_i[addr_shift_p +: IDX_W];

`ifdef BSG_DMC_UI_RESPONDER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16/14/13/11 (maximal length).
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) lfsr_q <= 16'hACE1;
    else            lfsr_q <= lfsr_d;
  end

  assign cmd_gate = lfsr_q[0];
  assign wdf_gate = lfsr_q[1];
`else
  assign cmd_gate = 1'b1;
  assign wdf_gate = 1'b1;
`endif

  // Write-data ready depends only on buffer occupancy, so data may lead the command.
  assign app_rdy_o     = calib_q & (state_q == S_IDLE) & cmd_gate;
  assign app_wdf_rdy_o = calib_q & (wcnt_q < BL_FULL) & wdf_gate;
  assign cmd_acc       = app_en_i & app_rdy_o;
  assign wdf_acc       = app_wdf_wren_i & app_wdf_rdy_o;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    calib_d    = calib_q;
    wcnt_d     = wcnt_q;
    wbuf_d     = wbuf_q;
    wmask_d    = wmask_q;
    mem_d      = mem_q;
    addr_idx_d = addr_idx_q;
    lat_d      = lat_q;
    beat_d     = beat_q;
    rd_valid_d = 1'b0;
    rd_end_d   = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = err_q;

    if (!calib_q) begin
      init_cnt_d = init_cnt_q + INIT_W'(1);
      if (init_cnt_q == INIT_LAST) calib_d = 1'b1;
    end

    if (wdf_acc) begin
      for (int b = 0; b < BL; b++) begin
        if (wcnt_q == CNT_W'(b)) begin
          wbuf_d[b]  = app_wdf_data_i;
          wmask_d[b] = app_wdf_mask_i;
        end
      end
      wcnt_d = wcnt_q + CNT_W'(1);
      // The end flag must mark exactly the beat that fills the buffer.
      if (app_wdf_end_i != (wcnt_q == BL_LAST_C)) err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          unique case (app_cmd_i)
            APP_CMD_WR: begin
              state_d    = S_WR;
              addr_idx_d = cmd_idx;
            end
            APP_CMD_RD: begin
              state_d    = S_RD_WAIT;
              addr_idx_d = cmd_idx;
              lat_d      = LAT_LOAD;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_WR: begin
        // wdf_rdy is low while full, so no beat can arrive in this cycle.
        if (wcnt_q == BL_FULL) begin
          for (int b = 0; b < BL; b++) begin
            for (int j = 0; j < MW; j++) begin
              if (!wmask_q[b][j]) mem_d[addr_idx_q][b][8*j +: 8] = wbuf_q[b][8*j +: 8];
            end
          end
          wcnt_d  = '0;
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          state_d = S_RD_DATA;
          beat_d  = '0;
        end
      end
      S_RD_DATA: begin
        if (beat_q == BEAT_LAST) state_d = S_IDLE;
        else                     beat_d  = beat_q + BEAT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Read outputs are registered from the next state so beat k lands
    // exactly rd_latency_p+1+k cycles after the accept.
    if (state_d == S_RD_DATA) begin
      rd_valid_d = 1'b1;
      rd_end_d   = (beat_d == BEAT_LAST);
      for (int b = 0; b < BL; b++) begin
        if (beat_d == BEAT_W'(b)) rd_data_d = mem_q[addr_idx_d][b];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      init_cnt_q <= '0;
      calib_q    <= 1'b0;
      wcnt_q     <= '0;
      addr_idx_q <= '0;
      lat_q      <= '0;
      beat_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_end_q   <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      for (int b = 0; b < BL; b++) begin
        wbuf_q[b]  <= '0;
        wmask_q[b] <= '0;
      end
      for (int i = 0; i < mem_els_p; i++) begin
        for (int b = 0; b < BL; b++) mem_q[i][b] <= '0;
      end
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      calib_q    <= calib_d;
      wcnt_q     <= wcnt_d;
      addr_idx_q <= addr_idx_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      rd_valid_q <= rd_valid_d;
      rd_end_q   <= rd_end_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      wbuf_q     <= wbuf_d;
      wmask_q    <= wmask_d;
      mem_q      <= mem_d;
    end
  end

  assign app_rd_data_valid_o   = rd_valid_q;
  assign app_rd_data_end_o     = rd_end_q;
  assign app_rd_data_o         = rd_data_q;
  assign init_calib_complete_o = calib_q;
  assign cmd_err_o             = err_q;

endmodule

// File: tb/tb_bsg_dmc_ui_responder.sv
// tb/tb_bsg_dmc_ui_responder.sv - self-checking bench for bsg_dmc_ui_responder

module tb_bsg_dmc_ui_responder;
  import bsg_dmc_ui_responder_pkg::*;

  localparam int L  = 4;
  localparam int BL = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [27:0]  app_addr = '0;
  app_cmd_e     app_cmd = APP_CMD_WR;
  logic         app_en = 1'b0;
  logic         app_rdy;
  logic         wren = 1'b0;
  logic [127:0] wdata = '0;
  logic [15:0]  wmask = '0;
  logic         wend = 1'b0;
  logic         wdf_rdy;
  logic         rd_valid;
  logic [127:0] rd_data;
  logic         rd_end;
  logic         calib;
  logic         err;

  always #5 clk = ~clk;

  bsg_dmc_ui_responder dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .app_addr_i(app_addr), .app_cmd_i(app_cmd), .app_en_i(app_en), .app_rdy_o(app_rdy),
    .app_wdf_wren_i(wren), .app_wdf_data_i(wdata), .app_wdf_mask_i(wmask),
    .app_wdf_end_i(wend), .app_wdf_rdy_o(wdf_rdy),
    .app_rd_data_valid_o(rd_valid), .app_rd_data_o(rd_data), .app_rd_data_end_o(rd_end),
    .init_calib_complete_o(calib), .cmd_err_o(err)
  );

  typedef struct {
    int           cyc;
    logic [127:0] data;
    logic         last;
  } exp_t;

  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;
  logic         in_reset = 1'b1;
  int           rel_cyc = 0;
  logic         model_err = 1'b0;
  int           beat_pos = 0;
  logic [127:0] model_mem [16][BL];
  exp_t         q[$];
  logic [127:0] cap_data [BL];
  int           cap_n = 0;
  int           cap_first_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every registered output against the model.
  always @(negedge clk) begin
    if (in_reset) begin
      check("reset_outputs", {rd_valid, rd_end, calib, err, app_rdy, wdf_rdy}, 6'b0);
      check("reset_rd_data", rd_data, '0);
    end else begin
      check("calib", calib, (cyc - rel_cyc) >= 8);
      check("cmd_err", err, model_err);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        check("rd_valid", rd_valid, 1'b1);
        check("rd_data", rd_data, q[0].data);
        check("rd_end", rd_end, q[0].last);
        if (cap_n == 0) cap_first_cyc = cyc;
        if (cap_n < BL) cap_data[cap_n] = rd_data;
        cap_n++;
        void'(q.pop_front());
      end else begin
        check("rd_valid_idle", rd_valid, 1'b0);
      end
    end
  end

  function automatic int idx_of(input logic [27:0] addr);
    return int'(addr >> 3) % 16;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < BL; b++) model_mem[i][b] = '0;
    model_err = 1'b0;
    beat_pos  = 0;
    q.delete();
  endtask

  task automatic apply_reset(input int hold);
    @(posedge clk); #1;
    rst_n = 1'b0; in_reset = 1'b1;
    app_en = 1'b0; wren = 1'b0; wend = 1'b0;
    clear_model();
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1; in_reset = 1'b0; rel_cyc = cyc;
  endtask

  task automatic wait_calib();
    int g = 0;
    while (!calib && g < 50) begin @(negedge clk); g++; end
    check("calib_wait", calib, 1'b1);
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr, output int acc);
    int g = 0;
    @(negedge clk);
    app_en = 1'b1; app_cmd = app_cmd_e'(cmd); app_addr = addr;
    while (!app_rdy && g < 100) begin @(negedge clk); g++; end
    check("cmd_rdy", app_rdy, 1'b1);
    acc = cyc;
    @(posedge clk); #1;
    app_en = 1'b0;
    if (cmd > 3'b001) model_err = 1'b1;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [15:0] m, input logic e);
    int g = 0;
    @(negedge clk);
    wren = 1'b1; wdata = d; wmask = m; wend = e;
    while (!wdf_rdy && g < 100) begin @(negedge clk); g++; end
    check("wdf_rdy", wdf_rdy, 1'b1);
    @(posedge clk); #1;
    wren = 1'b0; wend = 1'b0;
    if (e != (beat_pos == BL - 1)) model_err = 1'b1;
    beat_pos = (beat_pos + 1) % BL;
  endtask

  task automatic write_burst(input logic [27:0] addr, input logic [127:0] d0, input logic [127:0] d1,
                             input logic [15:0] m0, input logic e0, input logic e1, input bit data_first);
    int acc;
    logic [127:0] d [BL];
    logic [15:0]  m [BL];
    d[0] = d0; d[1] = d1; m[0] = m0; m[1] = '0;
    if (data_first) begin
      send_beat(d0, m0, e0);
      send_beat(d1, '0, e1);
      send_cmd(3'b000, addr, acc);
      @(negedge clk); check("rdy_commit_cycle", app_rdy, 1'b0);
      @(negedge clk); check("rdy_after_commit", app_rdy, 1'b1);
    end else begin
      send_cmd(3'b000, addr, acc);
      send_beat(d0, m0, e0);
      send_beat(d1, '0, e1);
    end
    for (int b = 0; b < BL; b++)
      for (int j = 0; j < 16; j++)
        if (!m[b][j]) model_mem[idx_of(addr)][b][8*j +: 8] = d[b][8*j +: 8];
  endtask

  task automatic do_read(input logic [27:0] addr, output int acc);
    int g = 0;
    cap_n = 0;
    send_cmd(3'b001, addr, acc);
    for (int k = 0; k < BL; k++)
      q.push_back('{cyc: acc + 1 + L + k, data: model_mem[idx_of(addr)][k], last: (k == BL - 1)});
    while (q.size() > 0 && g < 50) begin @(negedge clk); g++; end
    check("read_done", q.size(), 0);
    q.delete();
  endtask

  localparam logic [127:0] A  = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
  localparam logic [127:0] B  = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
  localparam logic [127:0] C0 = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
  localparam logic [127:0] C1 = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
  localparam logic [127:0] D0 = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] D1 = 128'h22222222_22222222_22222222_22222222;
  localparam logic [127:0] E0 = 128'h33333333_33333333_33333333_33333333;
  localparam logic [127:0] E1 = 128'h44444444_44444444_44444444_44444444;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int vcount;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; in_reset = 1'b0; rel_cyc = cyc;

    // Calibration edge: low through 7 cycles after release, high on the 8th.
    repeat (8) @(negedge clk);
    check("calib_at_7", calib, 1'b0);
    check("rdy_at_7", {app_rdy, wdf_rdy}, 2'b00);
    @(negedge clk);
    check("calib_at_8", calib, 1'b1);
    check("rdy_at_8", {app_rdy, wdf_rdy}, 2'b11);

    // Command-first write then read back.
    write_burst(28'h08, A, B, 16'h0000, 1'b0, 1'b1, 1'b0);
    do_read(28'h08, acc);
    check("first_beat_latency", cap_first_cyc - acc, 5);
    check("read_A", cap_data[0], A);
    check("read_B", cap_data[1], B);
    check("no_err", err, 1'b0);

    // Data-first write with byte 0 of beat 0 masked.
    write_burst(28'h08, C0, C1, 16'h0001, 1'b0, 1'b1, 1'b1);
    do_read(28'h08, acc);
    check("masked_beat0", cap_data[0], 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCEAF);
    check("masked_beat1", cap_data[1], C1);

    // Address aliasing on index 3.
    write_burst(28'h18, D0, D1, 16'h0000, 1'b0, 1'b1, 1'b0);
    do_read(28'h18 + (28'd16 << 3), acc);
    check("alias_beat0", cap_data[0], D0);
    check("alias_beat1", cap_data[1], D1);

    // End flag on the wrong beat: error latches, data still lands.
    write_burst(28'h20, E0, E1, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("end_err", err, 1'b1);
    do_read(28'h20, acc);
    check("end_err_data", cap_data[1], E1);

    // Reset during RD_WAIT aborts the read and zeroes memory.
    send_cmd(3'b001, 28'h08, acc);
    @(negedge clk);
    apply_reset(3);
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rd_valid) vcount++;
    end
    check("no_valid_after_reset", vcount, 0);
    wait_calib();
    do_read(28'h08, acc);
    check("zero_after_reset0", cap_data[0], '0);
    check("zero_after_reset1", cap_data[1], '0);

    // Unknown command: error sticks, FSM stays idle, no memory effect.
    check("err_cleared", err, 1'b0);
    send_cmd(3'b010, 28'h08, acc);
    @(negedge clk);
    check("bad_cmd_err", err, 1'b1);
    check("bad_cmd_idle", app_rdy, 1'b1);
    repeat (5) @(negedge clk);
    check("bad_cmd_sticky", err, 1'b1);
    do_read(28'h08, acc);
    check("bad_cmd_no_write", cap_data[0], '0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bsg_dmc_ui_responder.md
# bsg_dmc_ui_responder

Synthesizable responder for the DMC user interface (app_* command, write-data and read-data channels), emulating the controller side of the interface with a small register-backed burst memory. It sits where bsg_dmc normally sits, behind the trace-replay engine or any UI initiator. This allows loopback bring-up and regression of UI initiators without DDR, PHY, or calibration.

## Interface
Parameters:
- ui_addr_width_p, 28, app_addr_i width
- ui_data_width_p, 128, width of one UI beat
- ui_burst_len_p, 2, beats per command (power of two, ≥1)
- mem_els_p, 16, number of bursts stored (power of two)
- addr_shift_p, 3, low app_addr_i bits ignored when forming the burst index
- rd_latency_p, 4, idle cycles between read accept and first read beat (≥1)
- init_cycles_p, 8, cycles after reset release before calibration reports complete

Ports:
- clk_i  in  1  sole clock
- reset_n_i  in  1  asynchronous, active-low reset
- app_addr_i  in  ui_addr_width_p  command address
- app_cmd_i  in  app_cmd_e  command; WR=3'b000, RD=3'b001, all others "other"
- app_en_i  in  1  command valid
- app_rdy_o  out  1  command ready
- app_wdf_wren_i  in  1  write beat valid
- app_wdf_data_i  in  ui_data_width_p  write beat
- app_wdf_mask_i  in  ui_data_width_p/8  byte mask; 1 = byte NOT written
- app_wdf_end_i  in  1  last beat of burst
- app_wdf_rdy_o  out  1  write beat ready
- app_rd_data_valid_o  out  1  read beat valid (no backpressure)
- app_rd_data_o  out  ui_data_width_p  read beat
- app_rd_data_end_o  out  1  last read beat
- init_calib_complete_o  out  1  responder ready for traffic
- cmd_err_o  out  1  sticky protocol-error flag

## Operation
- Burst index = app_addr_i[addr_shift_p +: lg(mem_els_p)]. Higher address bits are ignored, so the index aliases.
- Init counter runs from reset release. init_calib_complete_o rises after exactly init_cycles_p cycles and stays high. Before that, app_rdy_o and app_wdf_rdy_o are 0.
- Write buffer holds ui_burst_len_p beats; beat counter is 0..ui_burst_len_p.
  - app_wdf_rdy_o = calib & (count < ui_burst_len_p), independent of FSM state. Data may lead the command.
  - A beat is accepted on wren & rdy.
  - app_wdf_end_i must be 1 exactly on the beat that fills the buffer. Any mismatch sets cmd_err_o; the beat is still stored.
- FSM states: IDLE, WR, RD_WAIT, RD_DATA.
  - IDLE: app_rdy_o = calib. On accept (en & rdy):
    - WR → WR
    - RD → RD_WAIT, with latency counter loaded to rd_latency_p
    - other → stays IDLE, sets cmd_err_o, no memory effect
  - WR: waits until count == ui_burst_len_p. On that cycle it commits all beats to the indexed burst, honoring per-byte masks. Same cycle: count clears, go to IDLE.
  - RD_WAIT: counter decrements; when it hits 0, go to RD_DATA.
  - RD_DATA: emits beats 0..ui_burst_len_p-1 on consecutive cycles, valid=1. end=1 on the last beat only, then go to IDLE.
  - app_rdy_o = 0 in every state except IDLE.
- A write beat accepted in the commit cycle is impossible: rdy=0 while count is full.
- Memory: zeroed on reset. Reads return committed contents only; uncommitted buffered beats are never forwarded.
- cmd_err_o clears only on reset.

## Timing
- Reset values of outputs:
  - 0: app_rdy_o, app_wdf_rdy_o, app_rd_data_valid_o, app_rd_data_end_o, init_calib_complete_o, cmd_err_o
  - app_rd_data_o = 0
- Read accepted at cycle t: beat k valid at t+1+rd_latency_p+k.
- Write accepted at t with buffer already full: commit at t+1; app_rdy_o high at t+2. Otherwise commit occurs the cycle after the last beat is accepted.
- Read accepted at or after commit+1 returns the new data.
- Asserting reset_n_i low mid-operation aborts immediately: FSM → IDLE, buffer discarded, memory zeroed, init counter restarts.
- All outputs are registered, except app_rdy_o and app_wdf_rdy_o, which are decoded from registered state and counters.

## Configuration
- BSG_DMC_UI_RESPONDER_STALL_EN defined:
  - A 16-bit LFSR (seed 16'hACE1 on reset) advances every cycle.
  - app_rdy_o and app_wdf_rdy_o are additionally ANDed with LFSR bit 0 and bit 1 respectively, giving pseudo-random backpressure.
  - Read-data timing is unaffected.
- Undefined: no LFSR; readies depend purely on state and counters as described above.

## Test plan
- Reset, hold idle → init_calib_complete_o rises exactly 8 cycles after release; app_rdy_o is 0 before that and 1 after.
- WR addr 0x08, beats A,B with end on B, mask 0; then RD addr 0x08 → read beats A then B, first beat at accept+5, end on B only, cmd_err_o=0.
- Write beats before the command (data-first) with mask 16'h0001 on beat 0 over a prior pattern → byte 0 of beat 0 keeps the old value; all other bytes are updated.
- Write to index 3 (addr 0x18); read addr 0x18+(16<<3) → aliased data returned.
- app_cmd_i=3'b010 accepted → no state change, cmd_err_o=1 and stays 1; end asserted on beat 0 of a 2-beat burst also sets the error.
- Reset asserted during RD_WAIT → valid never asserts; a subsequent read of the same address returns 0.
